// File: rtl/dac_ctrl_pkg.sv
// Shared state encoding, LTC2604 command codes and default timing for the DAC update path.
package dac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CS_LOW,
    WAIT_CS_HIGH,
    GAP
  } dac_state_t;

  localparam logic [3:0] LTC_CMD_WRITE        = 4'b0000;
  localparam logic [3:0] LTC_CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] LTC_CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] LTC_CMD_POWER_DOWN   = 4'b0100;

  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 48;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Round-robin pick: first requester found searching upward from last_grant+1, wrapping at N_REQ.
module dac_rr_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(N_REQ)) : sum[IDX_W-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    grant = last_grant;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant = cand_idx[k];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_update_arbiter.sv
// Arbitrates DAC update requests onto one SPI engine; one transfer at a time with a
// guard gap and a chip-select watchdog.
module dac_update_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int         N_REQ          = 4,
  parameter logic [3:0] DAC_CMD        = LTC_CMD_WRITE_UPDATE,
  parameter int         GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk25,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_value,
  input  logic [4*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]     ack,
  output logic                 err,
  output logic                 busy,
  output logic                 err_sticky,
  input  logic                 err_clr,
  output logic                 spi_tx_data,
  output logic [15:0]          spi_value,
  output logic [3:0]           spi_cmd,
  output logic [3:0]           spi_addr,
  input  logic                 spi_cs
);

  localparam int IDX_W = idx_width(N_REQ);

  dac_state_t       state_reg, state_next;
  logic [IDX_W-1:0] last_grant_reg, last_grant_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [15:0]      value_reg, value_next;
  logic [3:0]       addr_reg, addr_next;
  logic [3:0]       cmd_reg, cmd_next;
  logic             tx_reg, tx_next;
  logic [N_REQ-1:0] ack_reg, ack_next;
  logic             err_reg, err_next;
  logic             sticky_reg, sticky_next;
  logic [5:0]       tmo_cnt_reg, tmo_cnt_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic             tmo_hit;

  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic [15:0]      value_slot [N_REQ];
  logic [3:0]       addr_slot  [N_REQ];
  logic [N_REQ-1:0] grant_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign value_slot[gi]   = req_value[16*gi +: 16];
      assign addr_slot[gi]    = req_addr[4*gi +: 4];
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  dac_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    value_next      = value_reg;
    addr_next       = addr_reg;
    cmd_next        = cmd_reg;
    tx_next         = tx_reg;
    ack_next        = '0;
    err_next        = 1'b0;
    tmo_cnt_next    = tmo_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    tmo_hit         = (tmo_cnt_reg == 6'(TIMEOUT_CYCLES - 1));

    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          state_next      = ISSUE;
          grant_next      = arb_grant;
          last_grant_next = arb_grant;
          value_next      = value_slot[arb_grant];
          addr_next       = addr_slot[arb_grant];
          cmd_next        = DAC_CMD;
          tx_next         = 1'b1;
          tmo_cnt_next    = '0;
        end
      end
      ISSUE, WAIT_CS_LOW, WAIT_CS_HIGH: begin
        tmo_cnt_next = tmo_cnt_reg + 6'd1;
        // A completion seen on the watchdog's last cycle still counts as a success.
        if (state_reg == WAIT_CS_HIGH && spi_cs) begin
          ack_next     = grant_onehot;
          state_next   = GAP;
          gap_cnt_next = '0;
        end else if (tmo_hit) begin
          ack_next     = grant_onehot;
          err_next     = 1'b1;
          tx_next      = 1'b0;
          state_next   = GAP;
          gap_cnt_next = '0;
        end else if (state_reg == ISSUE) begin
          state_next = WAIT_CS_LOW;
        end else if (state_reg == WAIT_CS_LOW && !spi_cs) begin
          tx_next    = 1'b0;
          state_next = WAIT_CS_HIGH;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    sticky_next = err_next | (sticky_reg & ~err_clr);
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      grant_reg      <= '0;
      value_reg      <= '0;
      addr_reg       <= '0;
      cmd_reg        <= DAC_CMD;
      tx_reg         <= 1'b0;
      ack_reg        <= '0;
      err_reg        <= 1'b0;
      sticky_reg     <= 1'b0;
      tmo_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      value_reg      <= value_next;
      addr_reg       <= addr_next;
      cmd_reg        <= cmd_next;
      tx_reg         <= tx_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      sticky_reg     <= sticky_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign ack         = ack_reg;
  assign err         = err_reg;
  assign err_sticky  = sticky_reg;
  assign spi_tx_data = tx_reg;
  assign spi_value   = value_reg;
  assign spi_cmd     = cmd_reg;
  assign spi_addr    = addr_reg;

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Scoreboard bench for dac_update_arbiter with a behavioural SPI engine driving spi_cs.
module tb_dac_update_arbiter;

  localparam int         N_REQ          = 4;
  localparam int         GAP_CYCLES     = 2;
  localparam int         TIMEOUT_CYCLES = 48;
  localparam logic [3:0] CMD_WU         = 4'b0011;

  logic                 clk25 = 1'b0;
  logic                 reset_n;
  logic [N_REQ-1:0]     req;
  logic [16*N_REQ-1:0]  req_value;
  logic [4*N_REQ-1:0]   req_addr;
  logic [N_REQ-1:0]     ack;
  logic                 err;
  logic                 busy;
  logic                 err_sticky;
  logic                 err_clr;
  logic                 spi_tx_data;
  logic [15:0]          spi_value;
  logic [3:0]           spi_cmd;
  logic [3:0]           spi_addr;
  logic                 spi_cs;

  dac_update_arbiter #(
    .N_REQ(N_REQ), .DAC_CMD(CMD_WU), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk25       (clk25),
    .reset_n     (reset_n),
    .req         (req),
    .req_value   (req_value),
    .req_addr    (req_addr),
    .ack         (ack),
    .err         (err),
    .busy        (busy),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr),
    .spi_tx_data (spi_tx_data),
    .spi_value   (spi_value),
    .spi_cmd     (spi_cmd),
    .spi_addr    (spi_addr),
    .spi_cs      (spi_cs)
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [23:0] word;
    bit          is_err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rise_cyc = 0;
  int   last_ack_cyc = 0;
  bit   have_ack = 0;
  bit   prev_tx = 0;
  bit   stuck = 0;
  bit   found;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int i, input logic [3:0] a, input logic [15:0] v);
    req_value[16*i +: 16] = v;
    req_addr[4*i +: 4]    = a;
  endtask

  task automatic push_exp(input int i, input logic [3:0] a, input logic [15:0] v, input bit is_err);
    exp_t x;
    x.idx    = i;
    x.word   = {CMD_WU, a, v};
    x.is_err = is_err;
    exp_q.push_back(x);
  endtask

  task automatic wait_tx(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk25);
      if (spi_tx_data) begin
        seen = 1;
        break;
      end
    end
    check_eq(tag, 32'(seen), 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk25);
      if (exp_q.size() == 0) break;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // SPI engine: sees tx_data, drops CS two cycles later for three cycles.
  initial begin
    spi_cs = 1'b1;
    forever begin
      @(negedge clk25);
      if (!stuck && reset_n && spi_tx_data && spi_cs) begin
        repeat (2) @(negedge clk25);
        spi_cs = 1'b0;
        repeat (3) @(negedge clk25);
        spi_cs = 1'b1;
      end
    end
  end

  // Output monitor: pops one expectation per ack pulse.
  initial begin
    forever begin
      @(negedge clk25);
      if (!reset_n) begin
        have_ack = 0;
        prev_tx  = 0;
      end else begin
        if (spi_tx_data && !prev_tx) begin
          rise_cyc = cyc;
          if (have_ack) check_eq("gap", 32'((cyc - last_ack_cyc) >= GAP_CYCLES + 1), 1);
        end
        prev_tx = spi_tx_data;
        if (ack != '0 || err) begin
          check_eq("ack_onehot", $countones(ack), 1);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_ack", 32'(ack), 0);
          end else begin
            e = exp_q.pop_front();
            $display("xfer: ack=%b err=%0b word=%06h", ack, err, {spi_cmd, spi_addr, spi_value});
            check_eq("ack_idx", 32'(ack), 32'(1) << e.idx);
            check_eq("word", {8'h0, spi_cmd, spi_addr, spi_value}, {8'h0, e.word});
            check_eq("err", 32'(err), 32'(e.is_err));
            if (e.is_err) begin
              check_eq("tmo_latency", cyc - rise_cyc, TIMEOUT_CYCLES);
              check_eq("sticky_at_err", 32'(err_sticky), 1);
            end
          end
          last_ack_cyc = cyc;
          have_ack = 1;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; req = '0; req_value = '0; req_addr = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk25);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_tx", 32'(spi_tx_data), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_sticky", 32'(err_sticky), 0);
    check_eq("rst_cmd", 32'(spi_cmd), 32'(CMD_WU));
    check_eq("rst_value", 32'(spi_value), 0);
    check_eq("rst_addr", 32'(spi_addr), 0);
    reset_n = 1'b1;

    // Single request
    set_slot(0, 4'h2, 16'hA5C3);
    push_exp(0, 4'h2, 16'hA5C3, 0);
    req = 4'b0001;
    @(negedge clk25);
    check_eq("issue_tx", 32'(spi_tx_data), 1);
    check_eq("issue_busy", 32'(busy), 1);
    req = '0;
    wait_drain("single", 200);

    // Contention from a fresh reset: 0,1,2,3,0
    reset_n = 1'b0;
    @(negedge clk25);
    reset_n = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_slot(i, 4'(8 + i), 16'(16'h1111 * (i + 1)));
    for (int k = 0; k < 5; k++) push_exp(k % N_REQ, 4'(8 + k % N_REQ), 16'(16'h1111 * (k % N_REQ + 1)), 0);
    req = 4'b1111;
    wait_drain("contention", 400);
    req = '0;

    // Fairness: req[1] held, req[2] raised mid-transfer
    set_slot(1, 4'h5, 16'hBEEF);
    set_slot(2, 4'h6, 16'hCAFE);
    push_exp(1, 4'h5, 16'hBEEF, 0);
    push_exp(2, 4'h6, 16'hCAFE, 0);
    req = 4'b0010;
    wait_tx("fair_tx");
    req[2] = 1'b1;
    wait_drain("fair", 200);
    req = '0;

    // Data change after grant
    set_slot(3, 4'hC, 16'h1234);
    push_exp(3, 4'hC, 16'h1234, 0);
    req = 4'b1000;
    wait_tx("chg_tx");
    set_slot(3, 4'h1, 16'hFFFF);
    req = '0;
    wait_drain("chg", 200);

    // Timeout with CS stuck high
    stuck = 1;
    set_slot(0, 4'h7, 16'h0F0F);
    push_exp(0, 4'h7, 16'h0F0F, 1);
    req = 4'b0001;
    wait_tx("tmo_tx");
    req = '0;
    wait_drain("tmo", 200);
    @(negedge clk25);
    check_eq("sticky_set", 32'(err_sticky), 1);
    err_clr = 1'b1;
    @(negedge clk25);
    err_clr = 1'b0;
    check_eq("sticky_clr", 32'(err_sticky), 0);

    // Timeout while err_clr held: set wins
    err_clr = 1'b1;
    push_exp(0, 4'h7, 16'h0F0F, 1);
    req = 4'b0001;
    wait_tx("tmo2_tx");
    req = '0;
    wait_drain("tmo2", 200);
    repeat (2) @(negedge clk25);
    check_eq("sticky_clr2", 32'(err_sticky), 0);
    err_clr = 1'b0;
    stuck = 0;

    // Reset during WAIT_CS_HIGH
    set_slot(1, 4'h3, 16'h5A5A);
    push_exp(1, 4'h3, 16'h5A5A, 0);
    req = 4'b0010;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk25);
      if (busy && !spi_tx_data && !spi_cs) begin
        found = 1;
        break;
      end
    end
    check_eq("reach_wait_hi", 32'(found), 1);
    reset_n = 1'b0;
    exp_q.delete();
    req = '0;
    #1;
    check_eq("abort_tx", 32'(spi_tx_data), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_ack", 32'(ack), 0);
    repeat (8) @(negedge clk25);
    reset_n = 1'b1;
    repeat (4) @(negedge clk25);
    check_eq("post_rst_ack", 32'(ack), 0);

    push_exp(1, 4'h3, 16'h5A5A, 0);
    req = 4'b0010;
    wait_tx("post_rst_tx");
    req = '0;
    wait_drain("post_rst", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
